key_schedule_ctrl: RTL and testbench
====================================

// Module: key_schedule_ctrl
// PURPOSE
//  Sequences the combinational AES-128 round-key datapath (key_expansion) through the 10 rounds.
//  Latches the cipher key on start and drives the datapath one round per clock.
//  Feeds the datapath result back, storing all 11 round keys (rk0..rk10) in a local register file.
//  Cipher/decipher cores read round keys by index through a registered read port.
// PARAMETERS
//  NR     10   number of expansion rounds; fixed for AES-128
//  RK_AW  4    round-key index width; must satisfy 2**RK_AW > NR
// PORTS
//  clk         in   1    system clock, all logic on rising edge
//  rst         in   1    synchronous, active-high reset
//  start       in   1    request expansion of key_in; accepted only when ready=1
//  key_in      in   128  cipher key, sampled on the accepted start cycle
//  ready       out  1    controller idle, can accept start
//  done        out  1    one-cycle pulse: rk0..rk10 all written
//  keys_valid  out  1    round-key file holds a complete schedule
//  xp_key      out  128  previous round key, to datapath key input
//  xp_count    out  4    round index to datapath (0 selects Rcon 01, 9 selects Rcon 36)
//  xp_key_out  in   128  next round key from datapath (combinational from xp_key/xp_count)
//  rk_addr     in   4    round-key read index, 0..10
//  rk_data     out  128  round key rk[rk_addr], registered, 1-cycle read latency
// BEHAVIOUR
//  Reset values: state=IDLE, ready=1, done=0, keys_valid=0, xp_key=0, xp_count=0, rk_data=0, rk file=0.
//  FSM has two states.
//   IDLE: ready=1. If start=1, take the start:
//    - rk[0]<=key_in, xp_key<=key_in, xp_count<=0
//    - keys_valid<=0, go to EXPAND
//   EXPAND: ready=0. Every cycle:
//    - rk[xp_count+1]<=xp_key_out, xp_key<=xp_key_out
//    - if xp_count==NR-1: set done<=1 and keys_valid<=1, go to IDLE
//    - else: xp_count<=xp_count+1
//  Latency: start is sampled at edge E0; rk[n] is written at edge E(n); done is high in the cycle after E10.
//   That cycle is also the first with keys_valid=1 and ready=1.
//   start-to-done is 10 clocks.
//  In IDLE, xp_count holds 0 after reset. After a completed run it holds NR-1.
//   The datapath output is ignored outside EXPAND.
//  start while ready=0 is ignored: it is not queued and the key is not resampled.
//  start in the done cycle is accepted. The new run clears keys_valid on the next edge.
//   done and keys_valid deassert together.
//  Re-keying always clears keys_valid for the whole 10-cycle run. Consumers must not read during a run.
//  Read port: rk_data <= rk[rk_addr] on every edge, in all states.
//   A read issued on the same edge as a write to the same entry returns the old value.
//   rk_addr > 10 returns 128'h0.
//  Reset mid-expansion: the run is aborted immediately.
//   The FSM returns to IDLE, keys_valid=0, the rk file is cleared, and no done pulse is produced.
//  xp_count never exceeds NR-1. No wrap-around occurs.
// TESTING
//  1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c.
//     done at 10 clocks; rk[1]=a0fafe1788542cb123a339392a6c7605; rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
//  2. Pulse start again at cycles 3 and 7 of a run.
//     Ignored: single done, schedule unchanged, still matches scenario 1.
//  3. Key all-zero, start in the done cycle of a test-1 run.
//     keys_valid drops 1 cycle later; done 10 clocks later; rk[1]=6263636362636363...; rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
//  4. Assert rst at cycle 5 of a run.
//     Next cycle ready=1, keys_valid=0, all rk reads return 0, no done pulse.
//  5. Read sweep: rk_addr 0..15 after test 1.
//     rk_data matches the schedule one cycle later for 0..10; 0 for addresses 11..15.
//  6. Monitor xp_count during any run.
//     Sequence 0,1,..,9 on consecutive EXPAND cycles; ready=0 exactly 10 cycles.

Source files
------------

// File: rtl/key_schedule_ctrl_if.sv
// Bus between the AES-128 key-schedule controller, its external round-key
// datapath and the cipher cores that read round keys back.
interface key_schedule_ctrl_if #(
  parameter int RK_AW = 4
);
  logic             start;
  logic [127:0]     key_in;
  logic             ready;
  logic             done;
  logic             keys_valid;
  logic [127:0]     xp_key;
  logic [RK_AW-1:0] xp_count;
  logic [127:0]     xp_key_out;
  logic [RK_AW-1:0] rk_addr;
  logic [127:0]     rk_data;

  // Controller side
  modport slave (
    input  start, key_in, xp_key_out, rk_addr,
    output ready, done, keys_valid, xp_key, xp_count, rk_data
  );

  // Requester / datapath / consumer side
  modport master (
    output start, key_in, xp_key_out, rk_addr,
    input  ready, done, keys_valid, xp_key, xp_count, rk_data
  );
endinterface

// File: rtl/key_schedule_ctrl.sv
// AES-128 key-schedule sequencer: walks the combinational round-key datapath
// through NR rounds, one per clock, and stores rk0..rkNR in a local register
// file exposed through a registered read port.
module key_schedule_ctrl #(
  parameter int NR    = 10,
  parameter int RK_AW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  key_schedule_ctrl_if.slave   bus
);

  typedef enum logic {S_IDLE, S_EXPAND} state_t;

  state_t           state_q, state_d;
  logic [RK_AW-1:0] xp_count_q, xp_count_d;
  logic [127:0]     xp_key_q, xp_key_d;
  logic             keys_valid_q, keys_valid_d;
  logic             done_q, done_d;
  logic [127:0]     rk_q [0:NR];
  logic [127:0]     rk_data_q;

  logic             rk_we;
  logic [RK_AW-1:0] rk_wa;
  logic [127:0]     rk_wd;

  // State and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      xp_count_q   <= '0;
      xp_key_q     <= '0;
      keys_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      xp_count_q   <= xp_count_d;
      xp_key_q     <= xp_key_d;
      keys_valid_q <= keys_valid_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic; also selects which round-key entry is written this cycle
  always_comb begin
    state_d      = state_q;
    xp_count_d   = xp_count_q;
    xp_key_d     = xp_key_q;
    keys_valid_d = keys_valid_q;
    done_d       = 1'b0;
    rk_we        = 1'b0;
    rk_wa        = '0;
    rk_wd        = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rk_we        = 1'b1;
          rk_wa        = '0;
          rk_wd        = bus.key_in;
          xp_key_d     = bus.key_in;
          xp_count_d   = '0;
          keys_valid_d = 1'b0;
          state_d      = S_EXPAND;
        end
      end
      S_EXPAND: begin
        rk_we    = 1'b1;
        rk_wa    = xp_count_q + RK_AW'(1);
        rk_wd    = bus.xp_key_out;
        xp_key_d = bus.xp_key_out;
        if (xp_count_q == RK_AW'(NR - 1)) begin
          // Count stays at NR-1 so it never wraps past the last Rcon
          done_d       = 1'b1;
          keys_valid_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          xp_count_d = xp_count_q + RK_AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Round-key file; reset wipes every entry so an aborted run leaves no key material
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else if (rk_we) begin
      rk_q[rk_wa] <= rk_wd;
    end
  end

  // Registered read port; same-edge read of an entry being written sees the old value
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_data_q <= '0;
    end else if (bus.rk_addr <= RK_AW'(NR)) begin
      rk_data_q <= rk_q[bus.rk_addr];
    end else begin
      rk_data_q <= '0;
    end
  end

  assign bus.ready      = (state_q == S_IDLE);
  assign bus.done       = done_q;
  assign bus.keys_valid = keys_valid_q;
  assign bus.xp_key     = xp_key_q;
  assign bus.xp_count   = xp_count_q;
  assign bus.rk_data    = rk_data_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl. Provides a behavioural AES-128
// round-key datapath on xp_key/xp_count and checks the controller sequencing,
// the stored schedule and the read port.
module tb_key_schedule_ctrl;

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KA_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KA_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KZ_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] KZ_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   errors = 0;

  key_schedule_ctrl_if #(.RK_AW(4)) bus ();

  key_schedule_ctrl #(.NR(10), .RK_AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0: return 8'h01; 4'd1: return 8'h02; 4'd2: return 8'h04;
      4'd3: return 8'h08; 4'd4: return 8'h10; 4'd5: return 8'h20;
      4'd6: return 8'h40; 4'd7: return 8'h80; 4'd8: return 8'h1b;
      4'd9: return 8'h36; default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [3:0] i);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    t  = t ^ {rcon(i), 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Behavioural round-key datapath
  always_comb bus.xp_key_out = next_rk(bus.xp_key, bus.xp_count);

  logic [127:0] sched_a [0:10];
  logic [127:0] sched_z [0:10];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run: start is sampled on the next edge (E0)
  task automatic start_run(input logic [127:0] key);
    bus.start  = 1'b1;
    bus.key_in = key;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic sweep(input string tag, input logic [127:0] exp_tab [0:10], input logic zero);
    for (int a = 0; a < 16; a++) begin
      bus.rk_addr = 4'(a);
      tick();
      if (a <= 10) check_eq($sformatf("%s_rk%0d", tag, a), bus.rk_data, zero ? 128'h0 : exp_tab[a]);
      else         check_eq($sformatf("%s_oor%0d", tag, a), bus.rk_data, 128'h0);
    end
    bus.rk_addr = 4'd0;
  endtask

  int dones;

  initial begin
    sched_a[0] = KEY_A;
    sched_z[0] = 128'h0;
    for (int i = 1; i <= 10; i++) begin
      sched_a[i] = next_rk(sched_a[i-1], 4'(i-1));
      sched_z[i] = next_rk(sched_z[i-1], 4'(i-1));
    end

    rst = 1'b1; bus.start = 1'b0; bus.key_in = '0; bus.rk_addr = 4'd0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_ready", 128'(bus.ready), 128'd1);
    check_eq("rst_done", 128'(bus.done), 128'd0);
    check_eq("rst_kv", 128'(bus.keys_valid), 128'd0);
    check_eq("rst_xpkey", bus.xp_key, 128'h0);
    check_eq("rst_xpcnt", 128'(bus.xp_count), 128'd0);
    check_eq("rst_rkdata", bus.rk_data, 128'h0);

    // Scenario 1 + 6: FIPS-197 key, xp_count sequence, done latency
    start_run(KEY_A);
    for (int n = 1; n <= 10; n++) begin
      check_eq($sformatf("s1_cnt%0d", n - 1), 128'(bus.xp_count), 128'(n - 1));
      check_eq($sformatf("s1_busy%0d", n - 1), 128'(bus.ready), 128'd0);
      check_eq($sformatf("s1_nodone%0d", n - 1), 128'(bus.done), 128'd0);
      tick();
    end
    check_eq("s1_done", 128'(bus.done), 128'd1);
    check_eq("s1_kv", 128'(bus.keys_valid), 128'd1);
    check_eq("s1_ready", 128'(bus.ready), 128'd1);
    tick();
    check_eq("s1_done_pulse", 128'(bus.done), 128'd0);
    check_eq("s1_cnt_hold", 128'(bus.xp_count), 128'd9);
    bus.rk_addr = 4'd1;  tick(); check_eq("s1_rk1_const", bus.rk_data, KA_RK1);
    bus.rk_addr = 4'd10; tick(); check_eq("s1_rk10_const", bus.rk_data, KA_RK10);
    // Scenario 5: read sweep
    sweep("s5", sched_a, 1'b0);

    // Scenario 2: start pulses during a run are ignored
    start_run(KEY_A);
    dones = 0;
    for (int c = 1; c <= 14; c++) begin
      bus.start  = (c == 3 || c == 7);
      bus.key_in = 128'h0;
      tick();
      bus.start  = 1'b0;
      if (bus.done) begin
        dones++;
        check_eq("s2_done_at", 128'(c), 128'd10);
      end
    end
    check_eq("s2_done_count", 128'(dones), 128'd1);
    sweep("s2", sched_a, 1'b0);

    // Scenario 3: zero key accepted in the done cycle of a run
    start_run(KEY_A);
    for (int n = 1; n <= 10; n++) tick();
    check_eq("s3_done_a", 128'(bus.done), 128'd1);
    start_run(128'h0);
    check_eq("s3_kv_drop", 128'(bus.keys_valid), 128'd0);
    check_eq("s3_done_drop", 128'(bus.done), 128'd0);
    check_eq("s3_busy", 128'(bus.ready), 128'd0);
    for (int n = 1; n <= 9; n++) tick();
    check_eq("s3_not_yet", 128'(bus.done), 128'd0);
    tick();
    check_eq("s3_done_z", 128'(bus.done), 128'd1);
    bus.rk_addr = 4'd1;  tick(); check_eq("s3_rk1_const", bus.rk_data, KZ_RK1);
    bus.rk_addr = 4'd10; tick(); check_eq("s3_rk10_const", bus.rk_data, KZ_RK10);
    sweep("s3", sched_z, 1'b0);

    // Scenario 4: reset mid-expansion aborts the run and wipes the file
    start_run(KEY_A);
    for (int n = 1; n <= 4; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("s4_ready", 128'(bus.ready), 128'd1);
    check_eq("s4_kv", 128'(bus.keys_valid), 128'd0);
    check_eq("s4_done", 128'(bus.done), 128'd0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.done) dones++;
    end
    check_eq("s4_no_done", 128'(dones), 128'd0);
    sweep("s4", sched_a, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  // Bound on total run time
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests %0d errors %0d", tests, errors);
    $fatal(1);
  end

endmodule
